// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder controller.
// One 1-bit full-add slice is reused for WIDTH cycles, LSB first. Operands
// arrive through a valid/ready handshake and the WIDTH+1-bit sum leaves the
// same way. Every output is either a register or decoded from the FSM state.
module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Counter value of the final (MSB) bit slice.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum_q, sum_d;

    // Outputs of the shared 1-bit add slice.
    logic             slice_sum;
    logic             slice_carry;

    // The single full-add slice, fed from the operand LSBs and the carry flop.
    always_comb begin
        slice_sum   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        slice_carry = (a_sh_q[0] & b_sh_q[0]) |
                      (a_sh_q[0] & carry_q)   |
                      (b_sh_q[0] & carry_q);
    end

    // Next-state logic: operand capture, one bit per RUN cycle, result hold.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = in_a;
                    b_sh_d  = in_b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Write the slice result into the bit the counter points at.
                for (int i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sum_d[i] = slice_sum;
                    end
                end
                carry_d = slice_carry;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    // The carry-out of the MSB slice becomes the top sum bit.
                    sum_d[WIDTH] = slice_carry;
                    cnt_d        = '0;
                    state_d      = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // Result stays put until the consumer takes it.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight operation immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    // Handshake and status outputs decoded from state only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DONE);
        out_sum   = sum_q;
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, directed
// corner cases plus randomized operands and backpressure, checked against
// plain integer addition and the handshake timing rules.
module tb_serial_add_ctrl;

    logic clk;
    int   n_checks;
    int   n_fail;

    // WIDTH=8 instance
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_sum;
    logic       busy;

    // WIDTH=1 instance
    logic       rst1;
    logic       in_valid1;
    logic       in_ready1;
    logic [0:0] in_a1;
    logic [0:0] in_b1;
    logic       out_valid1;
    logic       out_ready1;
    logic [1:0] out_sum1;
    logic       busy1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full WIDTH=8 transaction with `hold` cycles of backpressure.
    task automatic txn8(input logic [7:0] a, input logic [7:0] b, input int hold);
        logic [8:0] exp_sum;
        int         lat;
        exp_sum = 9'(a) + 9'(b);
        check("w8_idle_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();                      // input handshake edge
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) check("w8_run_status", {busy, in_ready}, 2'b10);
            // Noise on the input side must not be captured mid-operation.
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            step();
            lat++;
        end
        in_valid = 1'b0;
        check("w8_latency", 64'(lat), 64'd8);
        check("w8_sum", out_sum, exp_sum);
        check("w8_done_busy", busy, 1'b1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            step();
            if (out_sum !== exp_sum || in_ready !== 1'b0 || out_valid !== 1'b1)
                check("w8_backpressure", {out_valid, in_ready, out_sum}, {1'b1, 1'b0, exp_sum});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();                      // output handshake edge
        out_ready = 1'b0;
        check("w8_after_out", {out_valid, in_ready, busy}, 3'b010);
        check("w8_sum_retained", out_sum, exp_sum);
        $display("w8 txn: %02h + %02h = %03h (expected %03h) latency %0d hold %0d",
                 a, b, out_sum, exp_sum, lat, hold);
    endtask

    // One WIDTH=1 transaction, output taken immediately.
    task automatic txn1(input logic a, input logic b);
        logic [1:0] exp_sum;
        exp_sum = 2'(a) + 2'(b);
        check("w1_idle_ready", in_ready1, 1'b1);
        in_valid1 = 1'b1;
        in_a1     = a;
        in_b1     = b;
        step();
        in_valid1 = 1'b0;
        check("w1_run", {busy1, out_valid1}, 2'b10);
        step();
        check("w1_valid", out_valid1, 1'b1);
        check("w1_sum", out_sum1, exp_sum);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("w1_after_out", {out_valid1, in_ready1}, 2'b01);
        $display("w1 txn: %0d + %0d = %02b (expected %02b)", a, b, out_sum1, exp_sum);
    endtask

    initial begin
        logic [7:0] pa [2];
        logic [7:0] pb [2];
        logic [8:0] got_sum [2];
        int         got_cyc [2];
        int         n_res;
        int         idx;
        int         cyc;
        logic       hs_in;
        logic       hs_out;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        rst1      = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        in_valid1 = 1'b0;
        in_a1     = '0;
        in_b1     = '0;
        out_ready1 = 1'b0;

        // Asynchronous reset before any clock edge.
        #2;
        rst  = 1'b1;
        rst1 = 1'b1;
        #1;
        check("reset_async", {in_ready, out_valid, busy, out_sum}, {1'b1, 1'b0, 1'b0, 9'h000});
        check("reset_async_w1", {in_ready1, out_valid1, busy1, out_sum1}, {1'b1, 1'b0, 1'b0, 2'b00});
        step();
        step();
        rst  = 1'b0;
        rst1 = 1'b0;
        step();

        // Directed sums and carry ripple corners.
        txn8(8'hA5, 8'h5A, 0);
        txn8(8'hFF, 8'h01, 0);
        txn8(8'hFF, 8'hFF, 0);
        txn8(8'h00, 8'h00, 0);
        // Long backpressure with input noise.
        txn8(8'h3C, 8'hC3, 20);

        // Randomized operands and backpressure.
        for (int t = 0; t < 20; t++) begin
            txn8(8'($urandom), 8'($urandom), int'($urandom_range(0, 5)));
        end

        // Back-to-back at full rate.
        pa[0] = 8'd3;   pb[0] = 8'd4;
        pa[1] = 8'd200; pb[1] = 8'd100;
        idx = 0;
        n_res = 0;
        cyc = 0;
        got_cyc[0] = 0;
        got_cyc[1] = 0;
        got_sum[0] = '0;
        got_sum[1] = '0;
        in_valid  = 1'b1;
        in_a      = pa[0];
        in_b      = pb[0];
        out_ready = 1'b1;
        while (n_res < 2 && cyc < 60) begin
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                got_sum[n_res] = out_sum;
                got_cyc[n_res] = cyc;
                n_res++;
            end
            step();
            cyc++;
            if (hs_in) begin
                idx++;
                if (idx < 2) begin
                    in_a = pa[idx];
                    in_b = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_results", 64'(n_res), 64'd2);
        check("b2b_sum0", got_sum[0], 9'h007);
        check("b2b_sum1", got_sum[1], 9'h12C);
        check("b2b_interval", 64'(got_cyc[1] - got_cyc[0]), 64'd10);
        $display("b2b txn: sums %03h %03h interval %0d", got_sum[0], got_sum[1], got_cyc[1] - got_cyc[0]);
        step();

        // Reset in the middle of RUN (counter at 4).
        in_valid = 1'b1;
        in_a     = 8'h80;
        in_b     = 8'h80;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        #2;
        rst = 1'b1;
        #1;
        check("midrun_reset", {in_ready, out_valid, busy, out_sum}, {1'b1, 1'b0, 1'b0, 9'h000});
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrun_no_valid", out_valid, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b0) check("post_reset_no_valid", out_valid, 1'b0);
        end
        $display("reset txn: 80 + 80 aborted at bit 4");
        txn8(8'h01, 8'h02, 0);

        // WIDTH=1 instance.
        txn1(1'b1, 1'b1);
        for (int t = 0; t < 6; t++) begin
            txn1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
